cache_ctrl_dm: RTL

CACHE_CTRL_DM -- requirements
Module: cache_ctrl_dm

---
 rtl/cache_pkg.sv | 15 +
 rtl/cache_tag_array.sv | 42 ++++
 rtl/cache_ctrl_dm.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared types and default geometry for the direct-mapped cache controller.
package cache_pkg;

    localparam int DEF_ADDR_W   = 10;
    localparam int DEF_INDEX_W  = 5;
    localparam int DEF_OFFSET_W = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/cache_tag_array.sv
// Tag and valid storage: registered write, combinational read, single-cycle clear of all valid bits.
module cache_tag_array #(
    parameter int INDEX_W = 5,
    parameter int TAG_W   = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               wr,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic [INDEX_W-1:0] rd_index,
    output logic [TAG_W-1:0]   rd_tag,
    output logic               rd_valid
);

    localparam int LINES = 1 << INDEX_W;

    logic [LINES-1:0] valid;
    logic [TAG_W-1:0] tags [LINES];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= '0;
        end else if (clear) begin
            valid <= '0;
        end else if (wr) begin
            valid[wr_index] <= 1'b1;
        end
    end

    // Tags need no reset: a line is only ever trusted through its valid bit.
    always_ff @(posedge clk) begin
        if (wr) begin
            tags[wr_index] <= wr_tag;
        end
    end

    assign rd_tag   = tags[rd_index];
    assign rd_valid = valid[rd_index];

endmodule

// File: rtl/cache_ctrl_dm.sv
// Direct-mapped write-through, no-write-allocate cache controller; zero-wait load hits.
// Define CACHE_STATS_EN to add saturating 32-bit hit_cnt/miss_cnt load counters.
module cache_ctrl_dm
    import cache_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int INDEX_W  = DEF_INDEX_W,
    parameter int OFFSET_W = DEF_OFFSET_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cpu_req,
    input  logic                cpu_we,
    input  logic [ADDR_W-1:0]   cpu_addr,
    input  logic                flush,
    output logic                cpu_stall,
    output logic                cpu_done,
    output logic                cache_rd,
    output logic                cache_wr,
    output logic                cache_fill,
    output logic [OFFSET_W-1:0] fill_word,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic                mem_ready
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]         hit_cnt,
    output logic [31:0]         miss_cnt
`endif
);

    localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
    localparam logic [OFFSET_W-1:0] LAST_WORD = '1;

    if (TAG_W < 1) begin : g_bad_geometry
        $error("cache_ctrl_dm: ADDR_W must exceed INDEX_W+OFFSET_W");
    end

    logic [TAG_W-1:0]   req_tag;
    logic [INDEX_W-1:0] req_index;
    logic [TAG_W-1:0]   line_tag;
    logic               line_valid;
    logic               hit;

    state_t              state, state_nxt;
    logic [OFFSET_W-1:0] fill_word_q;
    logic                tag_wr, tag_clear;

    logic                stall_c, done_c, rd_c, wr_c, fill_c, mreq_c, mwe_c;
    logic [ADDR_W-1:0]   maddr_c;

    assign req_tag   = cpu_addr[ADDR_W-1 -: TAG_W];
    assign req_index = cpu_addr[OFFSET_W +: INDEX_W];
    assign hit       = line_valid && (line_tag == req_tag);

    cache_tag_array #(
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W)
    ) u_tags (
        .clk      (clk),
        .rst      (rst),
        .clear    (tag_clear),
        .wr       (tag_wr),
        .wr_index (req_index),
        .wr_tag   (req_tag),
        .rd_index (req_index),
        .rd_tag   (line_tag),
        .rd_valid (line_valid)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            fill_word_q <= '0;
        end else begin
            state <= state_nxt;
            if (state == FILL && mem_ready) begin
                fill_word_q <= fill_word_q + 1'b1;
            end else if (state == IDLE) begin
                fill_word_q <= '0;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        tag_wr    = 1'b0;
        tag_clear = 1'b0;
        stall_c   = 1'b0;
        done_c    = 1'b0;
        rd_c      = 1'b0;
        wr_c      = 1'b0;
        fill_c    = 1'b0;
        mreq_c    = 1'b0;
        mwe_c     = 1'b0;
        maddr_c   = '0;
        case (state)
            IDLE: begin
                if (flush) begin
                    tag_clear = 1'b1;
                    stall_c   = cpu_req;
                end else if (cpu_req) begin
                    if (cpu_we) begin
                        stall_c   = 1'b1;
                        state_nxt = WRITE;
                    end else if (hit) begin
                        rd_c   = 1'b1;
                        done_c = 1'b1;
                    end else begin
                        stall_c   = 1'b1;
                        state_nxt = FILL;
                    end
                end
            end
            FILL: begin
                mreq_c  = 1'b1;
                stall_c = 1'b1;
                maddr_c = {req_tag, req_index, fill_word_q};
                if (mem_ready) begin
                    fill_c = 1'b1;
                    if (fill_word_q == LAST_WORD) begin
                        tag_wr    = 1'b1;
                        state_nxt = DONE;
                    end
                end
            end
            WRITE: begin
                mreq_c  = 1'b1;
                mwe_c   = 1'b1;
                stall_c = 1'b1;
                maddr_c = cpu_addr;
                if (mem_ready) begin
                    stall_c   = 1'b0;
                    done_c    = 1'b1;
                    wr_c      = hit;
                    state_nxt = IDLE;
                end
            end
            DONE: begin
                rd_c      = 1'b1;
                done_c    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Reset is asynchronous, so outputs are forced low directly rather than via state.
    assign cpu_stall  = rst & stall_c;
    assign cpu_done   = rst & done_c;
    assign cache_rd   = rst & rd_c;
    assign cache_wr   = rst & wr_c;
    assign cache_fill = rst & fill_c;
    assign mem_req    = rst & mreq_c;
    assign mem_we     = rst & mwe_c;
    assign mem_addr   = rst ? maddr_c : '0;
    assign fill_word  = fill_word_q;

`ifdef CACHE_STATS_EN
    logic load_hit_ev, load_miss_ev;

    assign load_hit_ev  = (state == IDLE) && !flush && cpu_req && !cpu_we && hit;
    assign load_miss_ev = (state == DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (load_hit_ev && hit_cnt != '1) begin
                hit_cnt <= hit_cnt + 32'd1;
            end
            if (load_miss_ev && miss_cnt != '1) begin
                miss_cnt <= miss_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
